// File: rtl/imem_boot_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_ctrl_defs : shared definitions for the instruction-memory boot
// controller (imem_boot_ctrl) and its read-port multiplexer (imem_port_mux).
//
// Contents:
//   DEF_DEPTH / DEF_ADDR_W : default memory depth (words) and word-index width
//   NOP_INSTR_DEF          : addi x0,x0,0, fed to the CPU while it is stalled
//   state_e                : controller state encoding
//   xor_fold               : checksum accumulation step
//
// Optional feature macro: IMEM_VERIFY_EN adds the VERIFY and ERROR states.
// ---------------------------------------------------------------------------
package imem_ctrl_defs;

  localparam int          DEF_DEPTH     = 256;
  localparam int          DEF_ADDR_W    = 8;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
`ifdef IMEM_VERIFY_EN
    ST_VERIFY = 3'd3,
    ST_ERROR  = 3'd4,
`endif
    ST_RUN    = 3'd2
  } state_e;

  // One step of the running XOR checksum over program words.
  function automatic logic [31:0] xor_fold(input logic [31:0] acc,
                                           input logic [31:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/imem_port_mux.sv
// ---------------------------------------------------------------------------
// imem_port_mux : read-port owner selection for the instruction memory.
//
// In RUN the CPU owns the read port: the fetch byte address is turned into a
// word index and the memory data goes straight to the CPU. In every other
// state the controller owns the address and the CPU sees a NOP.
//
// Ports:
//   state      in   controller state
//   ctrl_addr  in   controller-owned read word index
//   pc         in   CPU fetch byte address
//   imem_rdata in   combinational memory read data
//   imem_addr  out  memory read word index
//   instr      out  instruction delivered to the CPU
// ---------------------------------------------------------------------------
module imem_port_mux
  import imem_ctrl_defs::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  state_e            state,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [31:0]       pc,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       imem_addr,
  output logic [31:0]       instr
);

  // Byte-offset bits of the fetch address carry no information for a
  // word-addressed memory.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pc[1:0];

  // Select read address and delivered instruction from the current owner.
  always_comb begin
    imem_addr = 32'(ctrl_addr);
    instr     = NOP_INSTR;
    if (state == ST_RUN) begin
      imem_addr = {2'b00, pc[31:2]};
      instr     = imem_rdata;
    end else begin
      imem_addr = 32'(ctrl_addr);
      instr     = NOP_INSTR;
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl : boot / program-load controller for the instruction memory
// of a single-cycle RISC-V core.
//
// A load is started by a one-cycle start pulse carrying prog_len. Program
// words then arrive on a valid/ready stream and are written one per handshake
// through the memory write port, starting at word 0. The CPU is stalled (and
// fed NOPs) until the load completes; afterwards the read port belongs to the
// CPU fetch PC. A start pulse while running (or idle / in error) reloads.
//
// Optional feature macro: IMEM_VERIFY_EN
//   Written words are XOR-checksummed; after the last word the memory is read
//   back (one word per cycle) and its checksum compared. A mismatch parks the
//   controller in ERROR (err=1, CPU stalled) until the next start or reset.
//   Without the macro, LOAD goes straight to RUN and err is constant 0.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start, prog_len    load request pulse and word count (sampled on start)
//   in_valid/in_data   program word stream, in_ready accepts a word
//   pc                 CPU fetch byte address
//   imem_addr          memory read word index
//   imem_wreg/wdata/we memory write port
//   imem_rdata         combinational memory read data
//   instr, cpu_stall   instruction to the CPU and PC-hold request
//   busy, done, err    status; load_count = words written in this load
// ---------------------------------------------------------------------------
module imem_boot_ctrl
  import imem_ctrl_defs::*;
#(
  parameter int          DEPTH     = DEF_DEPTH,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  input  logic [31:0]       pc,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wreg,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   load_count,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] LEN_ZERO = (ADDR_W + 1)'(0);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic [ADDR_W:0]     last_idx;
  logic [ADDR_W:0]     clamped_len;
  logic [ADDR_W-1:0]   ctrl_addr;

`ifdef IMEM_VERIFY_EN
  logic [31:0]         csum_w_q, csum_w_d;
  logic [31:0]         csum_r_q, csum_r_d;
  logic [ADDR_W:0]     vaddr_q, vaddr_d;
`endif

  // The clamp keeps every write index below DEPTH, so waddr never wraps.
  assign clamped_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last_idx    = len_q - LEN_ONE;
  assign load_count  = load_count_q;

  // Next-state, counters, checksums and write-port drive.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    waddr_d      = waddr_q;
    load_count_d = load_count_q;
`ifdef IMEM_VERIFY_EN
    csum_w_d     = csum_w_q;
    csum_r_d     = csum_r_q;
    vaddr_d      = vaddr_q;
`endif
    in_ready     = 1'b0;
    imem_we      = 1'b0;
    imem_wreg    = 32'h0000_0000;
    imem_wdata   = 32'h0000_0000;
    ctrl_addr    = '0;

    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Write lands on this edge; start is deliberately ignored here.
          imem_we      = 1'b1;
          imem_wreg    = 32'(waddr_q);
          imem_wdata   = in_data;
          waddr_d      = waddr_q + 1'b1;
          load_count_d = load_count_q + LEN_ONE;
`ifdef IMEM_VERIFY_EN
          csum_w_d     = xor_fold(csum_w_q, in_data);
`endif
          if (load_count_q == last_idx) begin
`ifdef IMEM_VERIFY_EN
            state_d  = ST_VERIFY;
            vaddr_d  = LEN_ZERO;
            csum_r_d = 32'h0000_0000;
`else
            state_d  = ST_RUN;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          imem_we = 1'b0;
        end
      end

`ifdef IMEM_VERIFY_EN
      ST_VERIFY: begin
        // Read back one word per cycle and fold it into the read checksum.
        ctrl_addr = vaddr_q[ADDR_W-1:0];
        csum_r_d  = xor_fold(csum_r_q, imem_rdata);
        vaddr_d   = vaddr_q + LEN_ONE;
        if (vaddr_q == last_idx) begin
          if (csum_r_d == csum_w_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_VERIFY;
        end
      end
`endif

      ST_IDLE,
`ifdef IMEM_VERIFY_EN
      ST_ERROR,
`endif
      ST_RUN: begin
        // Any state that is not loading accepts a (re)load request.
        if (start) begin
          if (prog_len != LEN_ZERO) begin
            len_d        = clamped_len;
            waddr_d      = '0;
            load_count_d = LEN_ZERO;
`ifdef IMEM_VERIFY_EN
            csum_w_d     = 32'h0000_0000;
`endif
            state_d      = ST_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags decoded from the state so reset takes effect immediately.
  always_comb begin
    cpu_stall = (state_q != ST_RUN);
    done      = (state_q == ST_RUN);
`ifdef IMEM_VERIFY_EN
    busy      = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
    err       = (state_q == ST_ERROR);
`else
    busy      = (state_q == ST_LOAD);
    err       = 1'b0;
`endif
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= LEN_ZERO;
      waddr_q      <= '0;
      load_count_q <= LEN_ZERO;
`ifdef IMEM_VERIFY_EN
      csum_w_q     <= 32'h0000_0000;
      csum_r_q     <= 32'h0000_0000;
      vaddr_q      <= LEN_ZERO;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      waddr_q      <= waddr_d;
      load_count_q <= load_count_d;
`ifdef IMEM_VERIFY_EN
      csum_w_q     <= csum_w_d;
      csum_r_q     <= csum_r_d;
      vaddr_q      <= vaddr_d;
`endif
    end
  end

  imem_port_mux #(
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_port_mux (
    .state      (state_q),
    .ctrl_addr  (ctrl_addr),
    .pc         (pc),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .instr      (instr)
  );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for imem_boot_ctrl. A behavioural model tracks the load
// as a transaction (mode, words accepted, target length, expected memory
// image); one compare process checks every DUT output against it on each
// falling edge. Directed scenarios add literal expectations; a randomized
// phase follows. Build with +define+IMEM_VERIFY_EN to cover the verify path.
// ---------------------------------------------------------------------------
module tb_imem_boot_ctrl;

  localparam int          DEPTH  = 256;
  localparam int          ADDR_W = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IMEM_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_LOAD = 1, M_VERIFY = 2, M_RUN = 3, M_ERROR = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = 32'h0;
  logic [31:0]       pc = 32'h0;
  logic              in_ready, imem_we, cpu_stall, busy, done, err;
  logic [31:0]       imem_addr, imem_wreg, imem_wdata, imem_rdata, instr;
  logic [ADDR_W:0]   load_count;

  logic              mem_clear = 1'b1;
  logic              corrupt_req = 1'b0;
  logic [31:0]       mem [DEPTH];

  int n_checks = 0;
  int n_err    = 0;

  imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .prog_len   (prog_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .pc         (pc),
    .imem_addr  (imem_addr),
    .imem_wreg  (imem_wreg),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .cpu_stall  (cpu_stall),
    .busy       (busy),
    .done       (done),
    .load_count (load_count),
    .err        (err)
  );

  always #5 clock = ~clock;

  // Instruction memory: combinational read, write on rising edge, backdoor flip.
  assign imem_rdata = mem[imem_addr[7:0]];
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      if (imem_we) mem[imem_wreg[7:0]] <= imem_wdata;
      if (corrupt_req) mem[1] <= mem[1] ^ 32'h0000_0001;
    end
  end

  // ---------------- behavioural model ----------------
  int          m_mode = M_IDLE;
  int          m_len = 0, m_cnt = 0, m_vidx = 0;
  logic [31:0] m_csw = 32'h0, m_csr = 32'h0;
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
      if (mem_clear) for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    end else begin
      case (m_mode)
        M_LOAD: begin
          if (in_valid) begin
            ref_mem[m_cnt] = in_data;
            m_csw = m_csw ^ in_data;
            m_cnt = m_cnt + 1;
            if (m_cnt == m_len) begin
              if (VERIFY_ON) begin
                m_mode = M_VERIFY; m_vidx = 0; m_csr = 32'h0;
              end else begin
                m_mode = M_RUN;
              end
            end
          end
        end
        M_VERIFY: begin
          m_csr  = m_csr ^ mem[m_vidx];
          m_vidx = m_vidx + 1;
          if (m_vidx == m_len) m_mode = (m_csr == m_csw) ? M_RUN : M_ERROR;
        end
        default: begin
          if (start) begin
            if (prog_len != 0) begin
              m_len  = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
              m_cnt  = 0;
              m_csw  = 32'h0;
              m_mode = M_LOAD;
            end else begin
              m_mode = M_RUN;
            end
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    logic run, we;
    run = (m_mode == M_RUN);
    we  = (m_mode == M_LOAD) && in_valid;
    chk("in_ready",   32'(in_ready),   32'(m_mode == M_LOAD));
    chk("busy",       32'(busy),       32'(m_mode == M_LOAD || m_mode == M_VERIFY));
    chk("done",       32'(done),       32'(run));
    chk("cpu_stall",  32'(cpu_stall),  32'(!run));
    chk("err",        32'(err),        32'(m_mode == M_ERROR));
    chk("load_count", 32'(load_count), 32'(m_cnt));
    chk("imem_we",    32'(imem_we),    32'(we));
    chk("imem_wreg",  imem_wreg,       we ? 32'(m_cnt) : 32'h0);
    chk("imem_wdata", imem_wdata,      we ? in_data : 32'h0);
    chk("imem_addr",  imem_addr,       run ? (pc >> 2) : (m_mode == M_VERIFY ? 32'(m_vidx) : 32'h0));
    chk("instr",      instr,           run ? ref_mem[(pc >> 2) % DEPTH] : NOP);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Wait until the model leaves LOAD/VERIFY; an expired budget is a failure.
  task automatic settle(input int budget);
    int k;
    k = 0;
    while ((m_mode == M_LOAD || m_mode == M_VERIFY) && k < budget) begin
      step();
      k++;
    end
    if (m_mode == M_LOAD || m_mode == M_VERIFY) begin
      n_checks++;
      n_err++;
      $display("FAIL settle_timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic pulse_start(input int len);
    start    = 1'b1;
    prog_len = (ADDR_W + 1)'(len);
    step();
    start    = 1'b0;
  endtask

  initial begin
    logic [31:0] prog3 [3];
    int acc, cnt_we, len;
    prog3[0] = 32'h00A2_00B3;
    prog3[1] = 32'h0050_0113;
    prog3[2] = 32'h0020_81B3;

    repeat (3) @(posedge clock);
    #1;
    mem_clear = 1'b0;
    reset     = 1'b0;

    // Reset asserted mid-cycle during a load: outputs revert without an edge.
    pulse_start(5);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step(); step();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_instr",     instr,             32'h0000_0013);
    chk("rst_stall",     32'(cpu_stall),    32'h1);
    chk("rst_in_ready",  32'(in_ready),     32'h0);
    chk("rst_we",        32'(imem_we),      32'h0);
    chk("rst_count",     32'(load_count),   32'h0);
    chk("rst_busy_done", {busy, done, err}, 32'h0);
    chk("rst_addr",      imem_addr,         32'h0);
    in_valid = 1'b0;
    step();
    reset = 1'b0;

    // Three-word load with in_valid held high.
    pulse_start(3);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = prog3[i];
      #3;
      chk("ld3_we",   32'(imem_we), 32'h1);
      chk("ld3_wreg", imem_wreg,    32'(i));
      step();
    end
    in_valid = 1'b0; pc = 32'h4;
    #3;
    chk("ld3_done",  32'(done),      32'h1);
    chk("ld3_stall", 32'(cpu_stall), 32'h0);
    chk("ld3_instr", instr,          32'h0050_0113);
    step();

    // Valid pattern 1,0,0,1 while loading four words.
    pulse_start(4);
    cnt_we = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 0 || i == 3); in_data = $urandom;
      #3;
      if (imem_we) cnt_we++;
      step();
    end
    in_valid = 1'b0;
    #3;
    chk("gap_we_pulses", 32'(cnt_we),     32'h2);
    chk("gap_count",     32'(load_count), 32'h2);
    in_valid = 1'b1;
    settle(20);
    in_valid = 1'b0;
    step();

    // Reset at load_count=1 of 4, then a two-word reload from address 0.
    pulse_start(4);
    in_valid = 1'b1; in_data = 32'h1111_1111;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    #3;
    chk("mid_rst_count", 32'(load_count), 32'h0);
    chk("mid_rst_stall", 32'(cpu_stall),  32'h1);
    step();
    reset = 1'b0;
    pulse_start(2);
    in_valid = 1'b1; in_data = 32'h2222_2222;
    #3;
    chk("reload_wreg0", imem_wreg, 32'h0);
    step();
    in_data = 32'h3333_3333;
    settle(20);
    in_valid = 1'b0;
    step();

    // Zero length goes straight to RUN.
    pulse_start(0);
    #3;
    chk("len0_done", 32'(done), 32'h1);
    step();

    // Over-long request is clamped to DEPTH words.
    pulse_start(300);
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = $urandom;
      #3;
      if (in_ready) acc++;
      step();
    end
    #3;
    chk("clamp_accepted", 32'(acc),      32'd256);
    chk("clamp_ready",    32'(in_ready), 32'h0);
    in_valid = 1'b0;
    settle(600);
    step();

`ifdef IMEM_VERIFY_EN
    // Corrupt word 1 while the controller reads the image back.
    pulse_start(4);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    corrupt_req = 1'b1;
    step();
    corrupt_req = 1'b0;
    settle(20);
    #3;
    chk("vfy_err",   32'(err),       32'h1);
    chk("vfy_stall", 32'(cpu_stall), 32'h1);
    step();
    pulse_start(2);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    settle(20);
    #3;
    chk("vfy_clean_done", 32'(done), 32'h1);
    chk("vfy_clean_err",  32'(err),  32'h0);
    step();
`endif

    // Randomized loads, gaps, ignored starts, resets and fetches.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) len = 0;
      else if ($urandom_range(0, 19) == 0) len = $urandom_range(257, 300);
      else len = $urandom_range(1, 24);
      pulse_start(len);
      for (int k = 0; k < 1500 && m_mode == M_LOAD; k++) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = $urandom;
        start    = ($urandom_range(0, 15) == 0);
        prog_len = (ADDR_W + 1)'($urandom_range(0, 30));
        pc       = $urandom;
        if ($urandom_range(0, 199) == 0) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
        end else begin
          step();
        end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      settle(600);
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 3) == 0) pc = $urandom;
        else pc = {22'h0, 8'($urandom_range(0, (len > 0 && len < DEPTH) ? len - 1 : 0)), 2'($urandom)};
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
